pipe_hazard_ctrl: RTL and testbench

- Central sequencer for the 5-stage pipeline registers (PC, IF_ID, ID_EX, EX_MEM, MEM_WB).
- Each cycle it generates per-stage enables and synchronous flushes that drive each register's enable/reset inputs (e.g. enableMEM/resetMEM of MEM_WB).
- Resolves three hazards: load-use stall, taken-branch flush, and multi-cycle data-memory wait with timeout.

---
 rtl/pipe_hazard_ctrl_if.sv | 18 +
 rtl/pipe_hazard_ctrl.sv | 59 +++++
 tb/tb_pipe_hazard_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: hazard inputs and pipeline-register controls of the hazard sequencer
interface pipe_hazard_ctrl_if #(parameter int PERF_W = 16);
  logic [4:0] rs_id, rt_id, rt_ex;
  logic mem_rd_ex, br_taken_ex, mem_op_m, dmem_ack;
  logic enablePC, enableIF, enableID, enableEX, enableMEM;
  logic resetIF, resetID, resetMEM, dmem_req, timeout_err;
  logic [PERF_W-1:0] perf_stalls;
  modport master(
    output rs_id, rt_id, rt_ex, mem_rd_ex, br_taken_ex, mem_op_m, dmem_ack,
    input enablePC, enableIF, enableID, enableEX, enableMEM,
    input resetIF, resetID, resetMEM, dmem_req, timeout_err, perf_stalls
  );
  modport slave(
    input rs_id, rt_id, rt_ex, mem_rd_ex, br_taken_ex, mem_op_m, dmem_ack,
    output enablePC, enableIF, enableID, enableEX, enableMEM,
    output resetIF, resetID, resetMEM, dmem_req, timeout_err, perf_stalls
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: 5-stage pipeline enable/flush sequencer (load-use, branch, memory wait)
// PIPE_STALL_PERF_EN builds the saturating stall-cycle counter behind perf_stalls.
module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int PERF_W = 16
) (
  input logic reloj,
  input logic reset_n,
  pipe_hazard_ctrl_if.slave hz
);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  localparam logic [0:0] RUN = 1'b0;
  localparam logic [0:0] MEM_WAIT = 1'b1;
  logic [0:0] state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic err_q, err_d;
  logic mem_stall, br, lu;
  always_comb begin
    mem_stall = state_q == RUN ? hz.mem_op_m && !hz.dmem_ack : !hz.dmem_ack && cnt_q != LAST;
    br = !mem_stall && hz.br_taken_ex;
    lu = !mem_stall && !hz.br_taken_ex && hz.mem_rd_ex && hz.rt_ex != 5'd0 &&
         (hz.rt_ex == hz.rs_id || hz.rt_ex == hz.rt_id);
    state_d = mem_stall ? MEM_WAIT : RUN;
    // cnt_q is always zero in RUN, so one increment serves both entry and wait
    cnt_d = mem_stall ? cnt_q + CW'(1) : '0;
    err_d = err_q || (state_q == MEM_WAIT && !hz.dmem_ack && cnt_q == LAST);
  end
  always_ff @(posedge reloj or negedge reset_n)
    if (!reset_n) begin
      state_q <= RUN;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  assign hz.enablePC = reset_n && !mem_stall && !lu;
  assign hz.enableIF = reset_n && !mem_stall && !lu;
  assign hz.enableID = reset_n && !mem_stall;
  assign hz.enableEX = reset_n && !mem_stall;
  assign hz.enableMEM = reset_n && !mem_stall;
  assign hz.resetIF = !reset_n || br;
  assign hz.resetID = !reset_n || br || lu;
  assign hz.resetMEM = !reset_n || mem_stall;
  assign hz.dmem_req = reset_n && hz.mem_op_m;
  assign hz.timeout_err = err_q;
`ifdef PIPE_STALL_PERF_EN
  logic [PERF_W-1:0] perf_q, perf_d;
  always_comb perf_d = (!hz.enablePC && perf_q != '1) ? perf_q + PERF_W'(1) : perf_q;
  always_ff @(posedge reloj or negedge reset_n)
    if (!reset_n) perf_q <= '0;
    else perf_q <= perf_d;
  assign hz.perf_stalls = perf_q;
`else
  assign hz.perf_stalls = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed and random checks of pipe_hazard_ctrl against a behavioural model
module tb_pipe_hazard_ctrl;
  localparam int TIMEOUT = 16;
  localparam int PERF_W = 16;
  localparam logic [8:0] RST_V = 9'b00000_111_0;
  localparam logic [8:0] IDLE_V = 9'b11111_000_0;
  localparam logic [8:0] FRZ_V = 9'b00000_001_1;
  localparam logic [8:0] REL_V = 9'b11111_000_1;
  logic reloj = 1'b0;
  logic reset_n = 1'b0;
  always #5 reloj = ~reloj;
  pipe_hazard_ctrl_if #(.PERF_W(PERF_W)) hz();
  pipe_hazard_ctrl #(.TIMEOUT(TIMEOUT), .PERF_W(PERF_W)) dut (.reloj(reloj), .reset_n(reset_n), .hz(hz));
  int vectors = 0;
  int miscompares = 0;
  bit m_wait;
  int m_age;
  bit m_err;
  int m_perf;
  function automatic logic [8:0] dut_vec();
    return {hz.enablePC, hz.enableIF, hz.enableID, hz.enableEX, hz.enableMEM,
            hz.resetIF, hz.resetID, hz.resetMEM, hz.dmem_req};
  endfunction
  function automatic bit model_mem_stall();
    int acc = m_wait ? m_age + 1 : 1;
    return (m_wait || hz.mem_op_m) && !hz.dmem_ack && acc < TIMEOUT;
  endfunction
  function automatic logic [8:0] model_vec();
    bit lu = hz.mem_rd_ex && hz.rt_ex != 5'd0 && (hz.rt_ex == hz.rs_id || hz.rt_ex == hz.rt_id);
    if (!reset_n) return RST_V;
    if (model_mem_stall()) return {8'b00000_001, hz.mem_op_m};
    if (hz.br_taken_ex) return {8'b11111_110, hz.mem_op_m};
    if (lu) return {8'b00111_010, hz.mem_op_m};
    return {8'b11111_000, hz.mem_op_m};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic drv(input bit mem_op, input bit ack, input bit br, input bit mrd,
                     input logic [4:0] rtex, input logic [4:0] rs, input logic [4:0] rt);
    hz.mem_op_m = mem_op; hz.dmem_ack = ack; hz.br_taken_ex = br; hz.mem_rd_ex = mrd;
    hz.rt_ex = rtex; hz.rs_id = rs; hz.rt_id = rt;
  endtask
  task automatic model_reset();
    m_wait = 0; m_age = 0; m_err = 0; m_perf = 0;
  endtask
  task automatic step(input string name, input bit use_lit, input logic [8:0] lit);
    logic [8:0] mv;
    bit ms;
    int acc;
    @(negedge reloj);
    mv = model_vec();
    ms = model_mem_stall();
    chk({name, " outputs"}, 32'(dut_vec()), 32'(mv));
    if (use_lit) chk({name, " literal"}, 32'(dut_vec()), 32'(lit));
    chk({name, " timeout_err"}, 32'(hz.timeout_err), 32'(m_err));
    chk({name, " perf_stalls"}, 32'(hz.perf_stalls), 32'(m_perf));
    acc = m_wait ? m_age + 1 : 1;
    if (m_wait && !hz.dmem_ack && acc == TIMEOUT) m_err = 1;
`ifdef PIPE_STALL_PERF_EN
    if (!mv[8] && m_perf != (1 << PERF_W) - 1) m_perf++;
`endif
    m_wait = ms;
    m_age = ms ? acc : 0;
    @(posedge reloj);
    #1;
  endtask
  task automatic async_reset(input string name);
    reset_n = 1'b0;
    #1;
    chk({name, " outputs"}, 32'(dut_vec()), 32'(RST_V));
    chk({name, " timeout_err"}, 32'(hz.timeout_err), 32'd0);
    chk({name, " perf_stalls"}, 32'(hz.perf_stalls), 32'd0);
    model_reset();
    #1;
    reset_n = 1'b1;
  endtask
  initial begin
    bit long_mode = 0;
    drv(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge reloj);
    #1;
    chk("reset outputs", 32'(dut_vec()), 32'(RST_V));
    reset_n = 1'b1;
    step("idle", 1, IDLE_V);
    drv(0, 0, 0, 1, 5, 5, 0);
    step("load-use", 1, 9'b00111_010_0);
    drv(0, 0, 0, 0, 5, 5, 0);
    step("after load-use", 1, IDLE_V);
    drv(0, 0, 0, 1, 0, 0, 0);
    step("load-use r0", 1, IDLE_V);
    drv(0, 0, 1, 1, 5, 5, 0);
    step("branch over load-use", 1, 9'b11111_110_0);
    async_reset("reset before store");
    drv(1, 0, 0, 0, 0, 0, 0);
    repeat (3) step("store wait", 1, FRZ_V);
    drv(1, 1, 0, 0, 0, 0, 0);
    step("store ack", 1, REL_V);
`ifdef PIPE_STALL_PERF_EN
    chk("perf after store", 32'(hz.perf_stalls), 32'd3);
`else
    chk("perf after store", 32'(hz.perf_stalls), 32'd0);
`endif
    drv(1, 0, 0, 0, 0, 0, 0);
    repeat (TIMEOUT - 1) step("timeout wait", 1, FRZ_V);
    step("forced release", 1, REL_V);
    chk("timeout_err set", 32'(hz.timeout_err), 32'd1);
    drv(1, 1, 0, 0, 0, 0, 0);
    step("immediate ack", 1, REL_V);
    chk("timeout_err sticky", 32'(hz.timeout_err), 32'd1);
    drv(1, 0, 1, 0, 0, 0, 0);
    repeat (2) step("branch in wait", 1, FRZ_V);
    drv(1, 1, 1, 0, 0, 0, 0);
    step("branch release", 1, 9'b11111_110_1);
    drv(1, 0, 0, 0, 0, 0, 0);
    step("enter wait", 1, FRZ_V);
    async_reset("async reset in wait");
    drv(0, 0, 0, 0, 0, 0, 0);
    step("run after reset", 1, IDLE_V);
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) long_mode = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 499) == 0) async_reset("random reset");
      drv(m_wait ? 1'b1 : $urandom_range(0, 3) == 0,
          long_mode ? $urandom_range(0, 19) == 0 : $urandom_range(0, 2) == 0,
          $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1,
          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      step("random", 0, '0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
